// File: rtl/fifo_sync_ctrl.sv
// Pointer/flag controller for a single-clock FIFO. The memory is external;
// this block owns the binary wrap-bit pointers, occupancy and sticky errors.
module fifo_sync_ctrl #(
  parameter int P_DEPTH = 8,
  parameter int P_PTR_W = 4,
  parameter int P_AF_TH = 6,
  parameter int P_AE_TH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_en,
  input  logic               r_en,
  input  logic               i_flush,
  input  logic               i_clr_err,
  output logic [P_PTR_W-1:0] b_wptr,
  output logic [P_PTR_W-1:0] b_rptr,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [P_PTR_W-1:0] o_count,
  output logic               o_ovf,
  output logic               o_udf
);

  localparam logic [P_PTR_W-1:0] AF_TH = P_PTR_W'(P_AF_TH);
  localparam logic [P_PTR_W-1:0] AE_TH = P_PTR_W'(P_AE_TH);
  localparam logic [P_PTR_W-1:0] ONE   = P_PTR_W'(1);

  if (P_PTR_W != $clog2(P_DEPTH) + 1) begin : g_bad_ptr_w
    $error("fifo_sync_ctrl: P_PTR_W must be log2(P_DEPTH)+1");
  end

  logic wr_acc, rd_acc;

  // Flags come straight from the registered pointers, so a same-cycle read
  // never makes room for a write.
  assign o_empty = (b_wptr == b_rptr);
  assign o_full  = (b_wptr[P_PTR_W-2:0] == b_rptr[P_PTR_W-2:0]) &&
                   (b_wptr[P_PTR_W-1] != b_rptr[P_PTR_W-1]);
  assign o_count        = b_wptr - b_rptr;
  assign o_almost_full  = (o_count >= AF_TH);
  assign o_almost_empty = (o_count <= AE_TH);

  assign wr_acc = w_en & ~o_full;
  assign rd_acc = r_en & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wptr <= '0;
      b_rptr <= '0;
    end else if (i_flush) begin
      b_wptr <= '0;
      b_rptr <= '0;
    end else begin
      if (wr_acc) b_wptr <= b_wptr + ONE;
      if (rd_acc) b_rptr <= b_rptr + ONE;
    end
  end

  // A fresh error in the same cycle as a clear wins and keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      o_ovf <= (w_en & o_full)  | (o_ovf & ~i_clr_err);
      o_udf <= (r_en & o_empty) | (o_udf & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: an occupancy-based model queues the
// expected outputs per cycle, and a monitor compares them as they appear.
module tb_fifo_sync_ctrl;

  localparam int DEPTH = 8;
  localparam int PW    = 4;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0, r_en = 1'b0, i_flush = 1'b0, i_clr_err = 1'b0;
  logic [PW-1:0] b_wptr, b_rptr, o_count;
  logic          o_full, o_empty, o_almost_full, o_almost_empty, o_ovf, o_udf;

  fifo_sync_ctrl #(.P_DEPTH(DEPTH), .P_PTR_W(PW), .P_AF_TH(AF), .P_AE_TH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .i_flush(i_flush),
    .i_clr_err(i_clr_err), .b_wptr(b_wptr), .b_rptr(b_rptr), .o_full(o_full),
    .o_empty(o_empty), .o_almost_full(o_almost_full),
    .o_almost_empty(o_almost_empty), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          tgt;
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t q[$];
  event ev_now;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: occupancy plus free-running pointer counts.
  int occ = 0, wp = 0, rp = 0;
  bit ovf = 0, udf = 0;

  function automatic logic [17:0] model_vec();
    logic [PW-1:0] w4, r4, c4;
    w4 = PW'(wp % 16);
    r4 = PW'(rp % 16);
    c4 = PW'(occ);
    return {w4, r4, c4, occ == DEPTH, occ == 0, occ >= AF, occ <= AE, ovf, udf};
  endfunction

  function automatic void push(input int tgt, input string tag);
    exp_t e;
    e.tgt = tgt;
    e.tag = tag;
    e.v   = model_vec();
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    occ = 0; wp = 0; rp = 0; ovf = 0; udf = 0;
  endfunction

  task automatic step(input bit w, input bit r, input bit fl, input bit clr,
                      input string tag);
    bit full, empty, wacc, racc;
    @(posedge clk); #1;
    w_en = w; r_en = r; i_flush = fl; i_clr_err = clr;
    full  = (occ == DEPTH);
    empty = (occ == 0);
    wacc  = w && !full;
    racc  = r && !empty;
    ovf   = (w && full)  || (ovf && !clr);
    udf   = (r && empty) || (udf && !clr);
    if (fl) begin
      occ = 0; wp = 0; rp = 0;
    end else begin
      wp  = (wp + int'(wacc)) % 16;
      rp  = (rp + int'(racc)) % 16;
      occ = occ + int'(wacc) - int'(racc);
    end
    push(cyc + 1, tag);
  endtask

  // Asserts reset between edges and checks the outputs before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    w_en = 1'b1; r_en = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    push(cyc, tag);
    #1 -> ev_now;
    @(posedge clk); #1;
    rst_n = 1'b1; w_en = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle; compare whatever is due.
  initial begin
    forever begin
      @(negedge clk or ev_now);
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        exp_t e;
        logic [17:0] act;
        e   = q.pop_front();
        act = {b_wptr, b_rptr, o_count, o_full, o_empty, o_almost_full,
               o_almost_empty, o_ovf, o_udf};
        n_vec++;
        if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got wp=%h rp=%h cnt=%0d f/e/af/ae/ovf/udf=%b want wp=%h rp=%h cnt=%0d f/e/af/ae/ovf/udf=%b",
                   e.tag, cyc, act[17:14], act[13:10], act[9:6], act[5:0],
                   e.v[17:14], e.v[13:10], e.v[9:6], e.v[5:0]);
        end
      end
    end
  end

  initial begin
    bit wbias;
    #2;
    model_reset();
    push(cyc, "por");
    #1 -> ev_now;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, "fill");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "ovf");
    step(0, 0, 0, 1, "ovf_clr");
    step(1, 0, 0, 1, "ovf_clr_pri");
    step(0, 0, 0, 1, "ovf_clr2");
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, "drain");
    step(0, 1, 0, 0, "udf");
    step(0, 0, 0, 0, "udf_hold");
    step(0, 0, 0, 1, "udf_clr");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "pre_sim");
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, "simul");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "refill");
    step(1, 1, 0, 0, "full_wr_rd");
    step(0, 0, 0, 1, "full_clr");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, "to5");
    step(1, 0, 1, 0, "flush");
    step(1, 1, 0, 0, "post_flush");
    step(1, 0, 0, 0, "midfill");
    step(1, 0, 0, 0, "midfill");
    do_reset("mid_rst");
    step(0, 0, 0, 0, "post_rst");

    wbias = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) wbias = ~wbias;
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      else step($urandom_range(0, 99) < (wbias ? 75 : 30),
                $urandom_range(0, 99) < (wbias ? 30 : 75),
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 6, "rand");
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_q pending=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ctrl.md
FIFO_SYNC_CTRL -- requirements
Module: fifo_sync_ctrl

Interface
REQ-001 SHALL have parameter P_DEPTH, default 8, entries in the attached fifo memory (power of 2, at least 2).
REQ-002 SHALL have parameter P_PTR_W, default 4, pointer width equal to log2(P_DEPTH)+1.
REQ-003 SHALL have parameter P_AF_TH, default 6, almost-full threshold in entries.
REQ-004 SHALL have parameter P_AE_TH, default 2, almost-empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port r_en  input  1  read request.
REQ-009 SHALL have port i_flush  input  1  synchronous flush of FIFO contents.
REQ-010 SHALL have port i_clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port b_wptr  output  P_PTR_W  binary write pointer, MSB is the wrap bit; drives memory b_wptr.
REQ-012 SHALL have port b_rptr  output  P_PTR_W  binary read pointer, MSB is the wrap bit; drives memory b_rptr.
REQ-013 SHALL have port o_full  output  1  FIFO full; drives memory i_full.
REQ-014 SHALL have port o_empty  output  1  FIFO empty; drives memory i_empty.
REQ-015 SHALL have port o_almost_full  output  1  occupancy >= P_AF_TH.
REQ-016 SHALL have port o_almost_empty  output  1  occupancy <= P_AE_TH.
REQ-017 SHALL have port o_count  output  P_PTR_W  current occupancy, 0..P_DEPTH.
REQ-018 SHALL have port o_ovf  output  1  sticky overflow: a write was attempted while full.
REQ-019 SHALL have port o_udf  output  1  sticky underflow: a read was attempted while empty.

Function
REQ-020 SHALL accept a write (wr_acc) exactly when w_en=1 and o_full=0, and SHALL then increment b_wptr by 1 modulo 2^P_PTR_W at the next edge.
REQ-021 SHALL accept a read (rd_acc) exactly when r_en=1 and o_empty=0, and SHALL then increment b_rptr by 1 modulo 2^P_PTR_W at the next edge.
REQ-022 SHALL evaluate o_full and o_empty from the pointer values before the edge; a simultaneous read SHALL NOT free space for a write in the same cycle.
REQ-023 SHALL allow wr_acc and rd_acc in the same cycle; both pointers advance and o_count is unchanged.
REQ-024 SHALL drive o_empty=1 exactly when b_wptr == b_rptr.
REQ-025 SHALL drive o_full=1 exactly when the low P_PTR_W-1 bits of the pointers are equal and their MSBs differ.
REQ-026 SHALL drive o_count = (b_wptr - b_rptr) modulo 2^P_PTR_W.
REQ-027 SHALL derive o_full, o_empty, o_count and the almost flags combinationally from the registered pointers, with no extra latency.
REQ-028 SHALL reflect a write in o_empty and o_count one cycle after wr_acc; read data is available from the memory in the same cycle o_empty falls (first-word fall-through, no bypass when empty).
REQ-029 SHALL set o_ovf at the next edge when w_en=1 and o_full=1, and SHALL set o_udf at the next edge when r_en=1 and o_empty=1.
REQ-030 SHALL clear o_ovf and o_udf at the next edge when i_clr_err=1; a new error event in the same cycle SHALL take priority and leave the flag set.
REQ-031 SHALL set both pointers to 0 at the next edge when i_flush=1, overriding any simultaneous wr_acc or rd_acc; o_ovf and o_udf SHALL be unaffected by the flush itself.
REQ-032 SHALL handle wrap-around transparently: the pointer MSB toggles each time a pointer passes P_DEPTH-1, and no other state is involved.

Reset
REQ-033 SHALL, while rst_n=0, immediately force b_wptr=0, b_rptr=0, o_ovf=0 and o_udf=0, giving o_empty=1, o_full=0, o_count=0, o_almost_empty=1 and o_almost_full=0.
REQ-034 SHALL discard any in-flight operation on reset assertion and resume normal operation at the first rising clk edge after rst_n is released.

Verification
REQ-035 SHALL pass a fill test: 8 consecutive writes from reset -> o_count 1..8; o_almost_full=1 from count 6; o_full=1 at count 8; b_wptr=4'b1000, b_rptr=0.
REQ-036 SHALL pass an overflow test: w_en held while full -> b_wptr stays at 4'b1000, o_ovf=1 on the next cycle and remains 1 until i_clr_err is pulsed.
REQ-037 SHALL pass a drain and underflow test: 8 reads with no writes, then one more read -> o_empty=1, b_rptr=4'b1000, o_udf=1, o_almost_empty=1 once count <= 2.
REQ-038 SHALL pass a simultaneous-access test: at count 3, w_en=r_en=1 for 10 cycles -> o_count stays 3 and both pointers wrap past 4'b1111 to 4'b0000 with no flag change.
REQ-039 SHALL pass a full-boundary test: when full, w_en=r_en=1 -> only the read is accepted, o_count becomes 7 and o_ovf becomes 1.
REQ-040 SHALL pass a flush and reset test: i_flush with w_en=1 at count 5 -> pointers 0 and o_empty=1 on the next cycle; rst_n asserted mid-fill -> all outputs take reset values without waiting for a clock edge.
